// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, FSM state type and flag bundle for alu_multicycle.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry_out;
  } flags_t;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: iterative datapath for shifts (1 bit/cycle) and, when
// ALU_MUL_EN is defined, shift-add multiply over WIDTH cycles.
// done is asserted combinationally during the final step; res/flags then
// show the value the step produces so the parent can register it on that edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0] b,
`endif
  output logic             done,
  output logic [WIDTH-1:0] res,
  output flags_t           flags
);

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  logic [WIDTH-1:0] sh_q, sh_nxt;
  logic             shr_q, sh_out;
  logic [SHW:0]     cnt_q;

`ifdef ALU_MUL_EN
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  logic                 mul_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q, acc_nxt;
  logic [WIDTH-1:0]     mplier_q;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // one-bit shift step; the bit leaving the register becomes the carry
  always_comb begin
    sh_nxt = shr_q ? (sh_q >> 1) : (sh_q << 1);
    sh_out = shr_q ? sh_q[0] : sh_q[WIDTH-1];
  end

  assign done = run && (cnt_q == CNT_ONE);

  // iteration state: load on start, advance one step per EXEC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q     <= '0;
      shr_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef ALU_MUL_EN
      mul_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else if (start) begin
      sh_q     <= a;
      shr_q    <= (op == OP_SHR);
      cnt_q    <= {1'b0, shamt};
`ifdef ALU_MUL_EN
      mul_q    <= (op == OP_MUL);
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      if (op == OP_MUL) cnt_q <= CNT_MUL;
`endif
    end else if (run) begin
      sh_q     <= sh_nxt;
      cnt_q    <= cnt_q - CNT_ONE;
`ifdef ALU_MUL_EN
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
`endif
    end
  end

  // final-step result and flags presented to the output registers
  always_comb begin
    res             = sh_nxt;
    flags.overflow  = 1'b0;
    flags.carry_out = sh_out;
`ifdef ALU_MUL_EN
    if (mul_q) begin
      res             = acc_nxt[WIDTH-1:0];
      flags.overflow  = |acc_nxt[2*WIDTH-1:WIDTH];
      flags.carry_out = 1'b0;
    end
`endif
    flags.zero = (res == '0);
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshake on operands and
// result. Single-cycle ops return one cycle after accept; shifts and multiply
// iterate in alu_iter_unit. Optional multiply hardware: define ALU_MUL_EN.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut
);

  state_t           state_q, state_d;
  logic             accept, is_iter, iter_done;
  logic [WIDTH-1:0] bx, sc_res, iter_res;
  logic [WIDTH:0]   sum;
  logic             cin, c_into_msb;
  flags_t           sc_flg, iter_flg;
  logic [SHW-1:0]   shamt;

  assign shamt = B[SHW-1:0];

  // ops that need the iterative path rather than a one-cycle result
  always_comb begin
    is_iter = ((ALUOp == OP_SHL) || (ALUOp == OP_SHR)) && (shamt != '0);
`ifdef ALU_MUL_EN
    is_iter = is_iter || (ALUOp == OP_MUL);
`endif
  end

  // single-cycle datapath; SUB reuses the adder as A + ~B + 1
  always_comb begin
    cin        = (ALUOp == OP_SUB);
    bx         = cin ? ~B : B;
    sum        = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    c_into_msb = sum[WIDTH-1] ^ A[WIDTH-1] ^ bx[WIDTH-1];
    sc_res     = '0;
    sc_flg     = '0;
    case (ALUOp)
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_ADD, OP_SUB: begin
        sc_res           = sum[WIDTH-1:0];
        sc_flg.carry_out = sum[WIDTH];
        sc_flg.overflow  = c_into_msb ^ sum[WIDTH];
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SHL, OP_SHR: sc_res = A;  // only reached with shamt == 0
      default: sc_res = '0;        // MUL without multiply hardware
    endcase
    sc_flg.zero = (sc_res == '0);
  end

  assign accept = InValid && InReady;

  alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk   (Clk),
    .reset (Reset),
    .start (accept && is_iter),
    .run   (state_q == EXEC),
    .op    (ALUOp),
    .a     (A),
    .shamt (shamt),
`ifdef ALU_MUL_EN
    .b     (B),
`endif
    .done  (iter_done),
    .res   (iter_res),
    .flags (iter_flg)
  );

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and handshake outputs; HOLD passes OutReady through to
  // InReady so a retire and a new accept can share one edge
  always_comb begin
    state_d  = state_q;
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (state_q)
      IDLE: begin
        InReady = 1'b1;
        if (accept) state_d = is_iter ? EXEC : HOLD;
      end
      EXEC: begin
        if (iter_done) state_d = HOLD;
      end
      HOLD: begin
        OutValid = 1'b1;
        InReady  = OutReady;
        if (accept)        state_d = is_iter ? EXEC : HOLD;
        else if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // output registers: loaded on a single-cycle accept or on the last iteration
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Result   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else if (accept && !is_iter) begin
      Result                     <= sc_res;
      {Zero, Overflow, CarryOut} <= sc_flg;
    end else if (iter_done) begin
      Result                     <= iter_res;
      {Zero, Overflow, CarryOut} <= iter_flg;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vector table, hand-written handshake/reset
// sequences and randomized ops checked against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;
  logic         zero, ovf, cy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .A(a), .B(b), .ALUOp(op), .OutValid(out_valid), .OutReady(out_ready),
    .Result(result), .Zero(zero), .Overflow(ovf), .CarryOut(cy)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, v, c;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference: plain arithmetic on the operand values
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic z, output logic v,
                                output logic c, output int lat);
    int s;
    logic [W:0] t;
    logic [2*W-1:0] p;
    s = int'(y[3:0]);
    r = '0; v = 1'b0; c = 1'b0; lat = 1;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        t = {1'b0, x} + {1'b0, y};
        r = t[W-1:0]; c = t[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd3: begin
        r = x - y; c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd4: r = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      3'd5: begin
        r = x << s;
        if (s != 0) begin c = x[W-s]; lat = s + 1; end
      end
      3'd6: begin
        r = x >> s;
        if (s != 0) begin c = x[s-1]; lat = s + 1; end
      end
      default: begin
`ifdef ALU_MUL_EN
        p = x * y; r = p[W-1:0]; v = |p[2*W-1:W]; lat = W + 1;
`else
        p = '0; r = '0;
`endif
      end
    endcase
    z = (r == '0);
  endfunction

  // present one op, wait for accept, then return the result and its latency
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic z, output logic v,
                        output logic c, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result; z = zero; v = ovf; c = cy;
  endtask

  task automatic check_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r, er;
    logic z, v, c, ez, ev, ec;
    int lat, elat;
    model(o, x, y, er, ez, ev, ec, elat);
    run_op(o, x, y, r, z, v, c, lat);
    check({tag, " res"}, 32'(r), 32'(er));
    check({tag, " zero"}, 32'(z), 32'(ez));
    check({tag, " ovf"}, 32'(v), 32'(ev));
    check({tag, " carry"}, 32'(c), 32'(ec));
    check({tag, " lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    vec_t tbl[$];
    logic [W-1:0] r;
    logic z, v, c;
    int lat;

    tbl.push_back('{3'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{3'd3, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back('{3'd4, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd5, 16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{3'd6, 16'h0003, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 2});
`ifdef ALU_MUL_EN
    tbl.push_back('{3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17});
`else
    tbl.push_back('{3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
`endif
    tbl.push_back('{3'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd1, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd5, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 16});
    tbl.push_back('{3'd3, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd3, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst result", 32'(result), 0);
    check("rst flags", {29'd0, zero, ovf, cy}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", 32'(in_ready), 1);

    // directed vectors
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, v, c, lat);
      check($sformatf("vec%0d res", i), 32'(r), 32'(tbl[i].r));
      check($sformatf("vec%0d flags", i), {29'd0, z, v, c}, {29'd0, tbl[i].z, tbl[i].v, tbl[i].c});
      check($sformatf("vec%0d lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // backpressure: outputs frozen while OutReady low, then retire+accept together
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 16'h0100; b = 16'h0023;
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_SUB; a = 16'h0009; b = 16'h0001;
    check("bp valid", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp frozen res", 32'(result), 32'h0123);
      check("bp valid held", 32'(out_valid), 1);
      check("bp in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1; op = OP_ADD; a = 16'd2; b = 16'd3;
    #1 check("b2b in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b valid", 32'(out_valid), 1);
    check("b2b res", 32'(result), 5);
    @(posedge clk); #1;
    check("b2b retired", 32'(out_valid), 0);

    // reset during a MUL discards it
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = OP_MUL; a = 16'h0100; b = 16'h0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst out_valid", 32'(out_valid), 0);
    check("mrst result", 32'(result), 0);
    check("mrst flags", {29'd0, zero, ovf, cy}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("mrst in_ready", 32'(in_ready), 1);
    check_op("after-rst add", OP_ADD, 16'd2, 16'd3);

    // randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      check_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
